gen_scheduler: RTL

Generation scheduler for the life pipeline. It counts frames against the user speed setting and decides which frames run a generation pass through `life_logic`. It owns the ping-pong buffer select and swaps it at frame boundaries. It also serialises cursor-click edits so they never share the cell-memory write port with a generation pass.

---
 rtl/gen_scheduler_pkg.sv | 20 ++
 rtl/gen_scheduler_frame_divider.sv | 57 +++++
 rtl/gen_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/gen_scheduler_pkg.sv
// Shared types and constants for the life-pipeline generation scheduler.
//   LOG_MAX_SPEED_DEF : default width of the speed setting
//   MAX_SPEED         : number of speed steps (2**LOG_MAX_SPEED_DEF)
//   pos_t             : cell coordinate type used by cursor and edit paths
//   sched_state_t     : scheduler FSM states
package gen_scheduler_pkg;

  localparam int LOG_MAX_SPEED_DEF = 3;
  localparam int MAX_SPEED         = 2 ** LOG_MAX_SPEED_DEF;
  localparam int POS_W             = 6;

  typedef logic [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    GEN  = 2'd1,
    EDIT = 2'd2
  } sched_state_t;

endpackage

// File: rtl/gen_scheduler_frame_divider.sv
// Frame divider: counts frame_start pulses against the speed setting and
// raises a sticky "generation due" flag.
//   clk, rst     : clock, synchronous active-high reset
//   frame_start  : end-of-frame pulse
//   speed        : 0 = slowest, max = one generation per frame
//   run          : 1 = free-run (count frames), 0 = paused (count holds)
//   step         : single-generation request, honoured only while paused
//   due_clr      : consume the due flag (scheduler starting a generation)
//   due          : due flag, including a hit on the current frame_start
module frame_divider #(
  parameter int LOG_MAX_SPEED = gen_scheduler_pkg::LOG_MAX_SPEED_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [LOG_MAX_SPEED-1:0] speed,
  input  logic                     run,
  input  logic                     step,
  input  logic                     due_clr,
  output logic                     due
);

  localparam int CW = LOG_MAX_SPEED + 1;
  localparam logic [CW-1:0] MAX_P = {1'b1, {LOG_MAX_SPEED{1'b0}}};

  logic [CW-1:0] r_fcnt;
  logic [CW-1:0] w_fcnt_inc;
  logic [CW-1:0] w_period;
  logic          w_hit;
  logic          r_due;

  // Period is evaluated live, so lowering it below the running count
  // fires on the very next counted frame.
  assign w_period   = MAX_P - {1'b0, speed};
  assign w_fcnt_inc = r_fcnt + CW'(1);
  assign w_hit      = frame_start & run & (w_fcnt_inc >= w_period);

  // The hit is visible combinationally so the scheduler can start a pass
  // on the same frame_start that completes the count.
  assign due = r_due | w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt <= '0;
      r_due  <= 1'b0;
    end else begin
      if (frame_start && run)
        r_fcnt <= w_hit ? '0 : w_fcnt_inc;
      // Clear consumes everything visible on 'due' this cycle, including w_hit.
      if (due_clr)
        r_due <= 1'b0;
      else if (w_hit || (step && !run))
        r_due <= 1'b1;
    end
  end

endmodule

// File: rtl/gen_scheduler.sv
// Generation scheduler: decides which frames run a life_logic pass, owns
// the ping-pong buffer select, and serialises cursor edits so they never
// share the cell-memory write port with a generation pass.
//   clk, rst            : clock, synchronous active-high reset
//   frame_start_in      : end-of-active-scan pulse
//   speed_in, run_in    : speed setting, free-run level
//   step_in             : single generation while paused
//   click_in, cursor_*  : cell toggle request and its coordinates
//   edit_ready_in       : memory writer accepts the edit
//   gen_active_out      : life_logic writes the next generation this frame
//   rd_buf_out          : displayed/read buffer (write buffer is the other)
//   edit_valid_out, edit_x_out, edit_y_out : edit request
//   edit_overflow_out   : sticky, a click was dropped
//   gen_count_out       : completed generations (wraps)
//
// state | meaning
// WAIT  | no generation this frame; edits may issue
// GEN   | generation pass in progress
// EDIT  | edit handshake in flight
module gen_scheduler
  import gen_scheduler_pkg::*;
#(
  parameter int LOG_MAX_SPEED = LOG_MAX_SPEED_DEF,
  parameter int GEN_CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start_in,
  input  logic [LOG_MAX_SPEED-1:0] speed_in,
  input  logic                     run_in,
  input  logic                     step_in,
  input  logic                     click_in,
  input  pos_t                     cursor_x_in,
  input  pos_t                     cursor_y_in,
  input  logic                     edit_ready_in,
  output logic                     gen_active_out,
  output logic                     rd_buf_out,
  output logic                     edit_valid_out,
  output pos_t                     edit_x_out,
  output pos_t                     edit_y_out,
  output logic                     edit_overflow_out,
  output logic [GEN_CNT_W-1:0]     gen_count_out
);

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic r_pend_valid;
  pos_t r_pend_x;
  pos_t r_pend_y;

  logic w_due;
  logic w_due_clr;
  logic w_start_edit;
  logic w_end_gen;
  logic w_handshake;

  frame_divider #(
    .LOG_MAX_SPEED (LOG_MAX_SPEED)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start_in),
    .speed       (speed_in),
    .run         (run_in),
    .step        (step_in),
    .due_clr     (w_due_clr),
    .due         (w_due)
  );

  // A pending edit wins over a due frame; the due flag then stays set and
  // the pass starts on a later frame_start.
  always_comb begin
    w_state_nxt  = r_state;
    w_due_clr    = 1'b0;
    w_start_edit = 1'b0;
    w_end_gen    = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      WAIT: begin
        if (r_pend_valid) begin
          w_state_nxt  = EDIT;
          w_start_edit = 1'b1;
        end else if (frame_start_in && w_due) begin
          w_state_nxt = GEN;
          w_due_clr   = 1'b1;
        end
      end
      GEN: begin
        if (frame_start_in) begin
          w_state_nxt = WAIT;
          w_end_gen   = 1'b1;
        end
      end
      EDIT: begin
        if (edit_ready_in) begin
          w_state_nxt = WAIT;
          w_handshake = 1'b1;
        end
      end
      default: w_state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= WAIT;
      gen_active_out    <= 1'b0;
      rd_buf_out        <= 1'b0;
      edit_valid_out    <= 1'b0;
      edit_x_out        <= '0;
      edit_y_out        <= '0;
      edit_overflow_out <= 1'b0;
      gen_count_out     <= '0;
      r_pend_valid      <= 1'b0;
      r_pend_x          <= '0;
      r_pend_y          <= '0;
    end else begin
      r_state        <= w_state_nxt;
      gen_active_out <= (w_state_nxt == GEN);
      edit_valid_out <= (w_state_nxt == EDIT);

      if (w_end_gen) begin
        rd_buf_out    <= ~rd_buf_out;
        gen_count_out <= gen_count_out + GEN_CNT_W'(1);
      end

      if (w_start_edit) begin
        edit_x_out <= r_pend_x;
        edit_y_out <= r_pend_y;
      end

      // The entry freed by a handshake can take a click in the same cycle.
      if (click_in && (!r_pend_valid || w_handshake)) begin
        r_pend_valid <= 1'b1;
        r_pend_x     <= cursor_x_in;
        r_pend_y     <= cursor_y_in;
      end else if (w_handshake) begin
        r_pend_valid <= 1'b0;
      end

      if (click_in && r_pend_valid && !w_handshake)
        edit_overflow_out <= 1'b1;
    end
  end

endmodule
